// File: rtl/response_judge.sv
// response_judge: reads the player's switches through a synchroniser and debouncer,
// then judges them against a latched target inside a timed window (one hit or miss per pattern).
module response_judge #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int WINDOW_SECS   = 3
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             pattern_valid,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             hit,
    output logic             miss,
    output logic             busy,
    output logic [3:0]       secs_left
);
    // state   | meaning
    // IDLE    | waiting for a non-zero target pattern
    // JUDGE   | window open, sw_stable compared against target every cycle
    // RELEASE | outcome reported, waiting for every switch to be down
    typedef enum logic [1:0] {IDLE, JUDGE, RELEASE} state_t;

    localparam int DB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(STABLE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        SECS_LOAD = 4'(WINDOW_SECS);

    logic [1:0] rst_sync;
    logic       rst_int_n;

    // Reset asserts asynchronously but is released two clock edges later.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [DB_W-1:0]  db_cnt;

    // db_cnt counts down to terminal 0; any change in the next synced value reloads it.
    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync1     <= '0;
            sync2     <= '0;
            db_cnt    <= DB_LOAD;
            sw_stable <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync1 != sync2)    db_cnt    <= DB_LOAD;
            else if (db_cnt == '0) sw_stable <= sync2;
            else                   db_cnt    <= db_cnt - DB_W'(1);
        end
    end

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  target, target_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic [3:0]        secs_nxt;
    logic              hit_nxt, miss_nxt;

    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            target    <= '0;
            tick_cnt  <= TICK_LOAD;
            secs_left <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            tick_cnt  <= tick_nxt;
            secs_left <= secs_nxt;
            hit       <= hit_nxt;
            miss      <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        tick_nxt   = tick_cnt;
        secs_nxt   = secs_left;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pattern_valid && pattern != '0) begin
                    target_nxt = pattern;
                    secs_nxt   = SECS_LOAD;
                    tick_nxt   = TICK_LOAD;
                    state_nxt  = JUDGE;
                end
            end
            JUDGE: begin
                // Priority: full match, then a wrong switch, then window expiry.
                if (sw_stable == target) begin
                    hit_nxt   = 1'b1;
                    secs_nxt  = '0;
                    state_nxt = RELEASE;
                end else if (|(sw_stable & ~target)) begin
                    miss_nxt  = 1'b1;
                    secs_nxt  = '0;
                    state_nxt = RELEASE;
                end else if (tick_cnt == '0) begin
                    tick_nxt = TICK_LOAD;
                    if (secs_left == 4'd1) begin
                        miss_nxt  = 1'b1;
                        secs_nxt  = '0;
                        state_nxt = RELEASE;
                    end else begin
                        secs_nxt = secs_left - 4'd1;
                    end
                end else begin
                    tick_nxt = tick_cnt - TICK_W'(1);
                end
            end
            RELEASE: begin
                if (sw_stable == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
